life_array_ctrl: RTL

//  Sequencer for the Conway life cell array: issues global enb/scan/write/reset strobes to all cells.

---
 rtl/life_pkg.sv | 29 ++
 rtl/life_array_ctrl_if.sv | 11 +
 rtl/life_gen_timer.sv | 31 +++
 rtl/life_array_ctrl.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/life_pkg.sv
// Shared encodings for the life array sequencer: host opcodes, FSM states
// and a counter-width helper.
package life_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_NOP   = 3'd0,
    OP_RUN   = 3'd1,
    OP_STOP  = 3'd2,
    OP_STEP  = 3'd3,
    OP_SCAN  = 3'd4,
    OP_CLEAR = 3'd5
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN_WAIT,
    ST_STEP,
    ST_SCAN,
    ST_CLEAR
  } state_e;

  // Width of a counter covering 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/life_array_ctrl_if.sv
// Host command channel of the life array sequencer (valid/ready handshake).
interface life_array_ctrl_if;
  import life_pkg::*;

  logic            cmd_valid;
  logic [OP_W-1:0] cmd_op;
  logic            cmd_ready;

  modport master (output cmd_valid, output cmd_op, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_op, output cmd_ready);
endinterface

// File: rtl/life_gen_timer.sv
// Generation-rate down-counter: loads GEN_DIV-1, decrements on request,
// holds at zero and otherwise freezes its value.
module life_gen_timer
  import life_pkg::*;
#(
  parameter int GEN_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic dec,
  output logic zero
);

  localparam int            TW     = cnt_w(GEN_DIV);
  localparam logic [TW-1:0] RELOAD = TW'(GEN_DIV - 1);

  logic [TW-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset || load) begin
      count <= RELOAD;
    end else if (dec && (count != '0)) begin
      count <= count - TW'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/life_array_ctrl.sv
// Sequencer for the Conway life cell array: free-run, single-step, clear and
// toroidal scan readout. Optional auto-stop on empty array: LIFE_CTRL_AUTOSTOP_EN.
module life_array_ctrl
  import life_pkg::*;
#(
  parameter int ROWS    = 16,
  parameter int COLS    = 16,
  parameter int GEN_DIV = 4,
  parameter int GEN_W   = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  life_array_ctrl_if.slave       cmd,
  input  logic                   host_write,
  input  logic                   array_alive,
  output logic                   cell_enb,
  output logic                   cell_scan,
  output logic                   cell_write,
  output logic                   cell_reset,
  output logic                   scan_valid,
  output logic [cnt_w(COLS)-1:0] scan_col,
  output logic                   running,
  output logic [GEN_W-1:0]       gen_count
);

  localparam int            CW          = cnt_w(COLS);
  localparam logic [CW-1:0] LAST_COL    = CW'(COLS - 1);
  localparam int            unused_rows = ROWS;

  state_e state, state_nxt;
  logic   running_nxt;
  logic   accept;
  logic   timer_load, timer_dec, timer_zero;

  assign cmd.cmd_ready = (state == ST_IDLE) || (state == ST_RUN_WAIT);
  assign accept        = cmd.cmd_valid && cmd.cmd_ready;

`ifdef LIFE_CTRL_AUTOSTOP_EN
  // Marks the first RUN_WAIT cycle, when array_alive reflects the new generation.
  logic just_stepped;
  always_ff @(posedge clk) begin
    if (reset) just_stepped <= 1'b0;
    else       just_stepped <= (state == ST_STEP);
  end
`else
  logic unused_alive;
  assign unused_alive = array_alive;
`endif

  always_comb begin
    // NOTE: every comb output gets a default first, so no path can infer a latch.
    state_nxt   = state;
    running_nxt = running;
    timer_load  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (accept) begin
          case (cmd.cmd_op)
            OP_RUN: begin
              running_nxt = 1'b1;
              timer_load  = 1'b1;
              state_nxt   = ST_RUN_WAIT;
            end
            OP_STEP:  state_nxt = ST_STEP;
            OP_SCAN:  state_nxt = ST_SCAN;
            OP_CLEAR: state_nxt = ST_CLEAR;
            default:  state_nxt = ST_IDLE;
          endcase
        end
      end
      ST_RUN_WAIT: begin
        // Host commands outrank the pending step; SCAN leaves the timer frozen.
        if (accept && (cmd.cmd_op == OP_CLEAR)) begin
          running_nxt = 1'b0;
          state_nxt   = ST_CLEAR;
        end else if (accept && (cmd.cmd_op == OP_STOP)) begin
          running_nxt = 1'b0;
          state_nxt   = ST_IDLE;
        end else if (accept && (cmd.cmd_op == OP_SCAN)) begin
          state_nxt = ST_SCAN;
`ifdef LIFE_CTRL_AUTOSTOP_EN
        end else if (just_stepped && !array_alive) begin
          running_nxt = 1'b0;
          state_nxt   = ST_IDLE;
`endif
        end else if (timer_zero) begin
          state_nxt = ST_STEP;
        end
      end
      ST_STEP: begin
        if (running) begin
          timer_load = 1'b1;
          state_nxt  = ST_RUN_WAIT;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_SCAN: begin
        if (scan_col == LAST_COL) state_nxt = running ? ST_RUN_WAIT : ST_IDLE;
      end
      ST_CLEAR: begin
        running_nxt = 1'b0;
        state_nxt   = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign timer_dec = (state == ST_RUN_WAIT) && (state_nxt == ST_RUN_WAIT);

  life_gen_timer #(.GEN_DIV(GEN_DIV)) u_timer (
    .clk   (clk),
    .reset (reset),
    .load  (timer_load),
    .dec   (timer_dec),
    .zero  (timer_zero)
  );

  // Strobes are registered from the next state, so each one lines up with its state cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      running    <= 1'b0;
      gen_count  <= '0;
      cell_enb   <= 1'b0;
      cell_scan  <= 1'b0;
      cell_write <= 1'b0;
      cell_reset <= 1'b0;
      scan_valid <= 1'b0;
      scan_col   <= '0;
    end else begin
      state   <= state_nxt;
      running <= running_nxt;
      if (state == ST_CLEAR)     gen_count <= '0;
      else if (state == ST_STEP) gen_count <= gen_count + GEN_W'(1);
      cell_enb   <= (state_nxt == ST_STEP);
      cell_scan  <= (state_nxt == ST_SCAN);
      scan_valid <= (state_nxt == ST_SCAN);
      cell_reset <= (state_nxt == ST_CLEAR);
      cell_write <= (state == ST_IDLE) && (state_nxt == ST_IDLE) && host_write;
      scan_col   <= ((state == ST_SCAN) && (state_nxt == ST_SCAN)) ? scan_col + CW'(1) : '0;
    end
  end

endmodule
